// File: rtl/char_rom_pkg.sv
// Shared definitions for the UART message ROM: table depth, ASCII constants
// and the byte lookup used by the ROM and the transmit sequencer.
package char_rom_pkg;

  localparam int CHAR_ROM_DEPTH = 32;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_A   = 8'h41;
  localparam logic [7:0] ASCII_0   = 8'h30;

  // Unknown or out-of-table addresses fall through to NUL, the end-of-message marker.
  function automatic logic [7:0] char_rom_lookup(input logic [31:0] addr);
    logic [7:0] byte_s;
    byte_s = ASCII_NUL;
    case (addr) inside
      [32'd0:32'd25]:                byte_s = ASCII_A + addr[7:0];
      [32'd26:32'd29]:               byte_s = ASCII_0 + (addr[7:0] - 8'd26);
      32'(CHAR_ROM_DEPTH - 2):       byte_s = ASCII_CR;
      32'(CHAR_ROM_DEPTH - 1):       byte_s = ASCII_LF;
      default:                       byte_s = ASCII_NUL;
    endcase
    return byte_s;
  endfunction

endpackage

// File: rtl/char_rom.sv
// Synchronous 32-entry ASCII message ROM feeding the UART TX data path.
// Define CHAR_ROM_OUTREG_EN to add a second output register (2-cycle latency).
module char_rom
  import char_rom_pkg::*;
#(
  parameter int ROM_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [ROM_ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0]     o_dout
);

  generate
    if (DATA_WIDTH != 8) begin : g_bad_width
      $error("char_rom: DATA_WIDTH must be 8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] rom_data_s;
  logic [DATA_WIDTH-1:0] stage1_r;

  // Combinational table lookup; infers a LUT/BRAM ROM.
  always_comb begin
    rom_data_s = DATA_WIDTH'(char_rom_lookup(32'(i_addr)));
  end

  // First output stage: registered table byte.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage1_r <= DATA_WIDTH'(8'h00);
    end else begin
      stage1_r <= rom_data_s;
    end
  end

`ifdef CHAR_ROM_OUTREG_EN
  logic [DATA_WIDTH-1:0] stage2_r;

  // Optional BRAM output register for timing closure.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage2_r <= DATA_WIDTH'(8'h00);
    end else begin
      stage2_r <= stage1_r;
    end
  end

  assign o_dout = stage2_r;
`else
  assign o_dout = stage1_r;
`endif

endmodule

// File: tb/tb_char_rom.sv
// Self-checking bench for char_rom: default-width and 6-bit-address instances
// driven in lockstep, expected bytes queued at drive time and popped at output.
module tb_char_rom;

`ifdef CHAR_ROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] addr5;
  logic [5:0] addr6;
  logic [7:0] dout5;
  logic [7:0] dout6;

  int checks = 0;
  int errors = 0;
  logic [7:0] q5[$];
  logic [7:0] q6[$];
  string msg;

  always #5 clk = ~clk;

  char_rom #(.ROM_ADDR_WIDTH(5), .DATA_WIDTH(8)) dut5 (
    .i_clk(clk), .i_rstn(rstn), .i_addr(addr5), .o_dout(dout5)
  );

  char_rom #(.ROM_ADDR_WIDTH(6), .DATA_WIDTH(8)) dut6 (
    .i_clk(clk), .i_rstn(rstn), .i_addr(addr6), .o_dout(dout6)
  );

  function automatic logic [7:0] ref_byte(input int a);
    if (a < 32) return 8'(msg[a]);
    else return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive, queue expectation, advance one edge, compare.
  task automatic step(input int a);
    addr5 = 5'(a);
    addr6 = 6'(a);
    q5.push_back(ref_byte(a % 32));
    q6.push_back(ref_byte(a));
    @(posedge clk);
    #1;
    if (q5.size() >= LAT) check($sformatf("w5_addr%0d", a), dout5, q5.pop_front());
    if (q6.size() >= LAT) check($sformatf("w6_addr%0d", a), dout6, q6.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    msg = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123\r\n";
    rstn  = 1'b0;
    addr5 = 5'd5;
    addr6 = 6'd5;

    // Reset held for 10 cycles with address 5.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_w5", dout5, 8'h00);
      check("reset_w6", dout6, 8'h00);
    end

    // Release and expect 'F' after the read latency.
    rstn = 1'b1;
    for (int i = 0; i < LAT; i++) step(5);

    // Full sweep 0..31.
    for (int i = 0; i < 32; i++) step(i);

    // Wrap 30, 31, 0, 1.
    step(30);
    step(31);
    step(0);
    step(1);

    // Wide-address instance: beyond-table addresses are NUL.
    step(32);
    step(63);
    step(25);

    // Mid-stream reset while output shows 'K'.
    for (int i = 0; i < LAT; i++) step(10);
    check("pre_reset_K", dout5, 8'h4B);
    #2;
    rstn = 1'b0;
    #1;
    check("midreset_w5", dout5, 8'h00);
    check("midreset_w6", dout6, 8'h00);
    addr5 = 5'd2;
    addr6 = 6'd2;
    @(posedge clk);
    #1;
    check("held_reset_w5", dout5, 8'h00);
    q5.delete();
    q6.delete();
    rstn = 1'b1;
    for (int i = 0; i < LAT; i++) step(2);

    // Back-to-back 0 then 1 after recovery, then drain the pipeline.
    step(0);
    step(1);
    for (int i = 1; i < LAT; i++) step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_rom.md
Name: char_rom

Overview:
- Synchronous read-only character table holding a fixed 32-entry ASCII message for the UART transmit path.
- A sequencer presents an address each cycle; the ROM returns the stored byte one clock later.
- Sits between the message-index counter and the UART TX data input.
- Pure lookup: no handshake, no write port.

Parameters:
- ROM_ADDR_WIDTH, default 5, address width; addressable depth is 2**ROM_ADDR_WIDTH.
- DATA_WIDTH, default 8, output byte width; only 8 is supported, other values are a synthesis-time error.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_addr  input  ROM_ADDR_WIDTH  read address.
- o_dout  output  DATA_WIDTH  registered character byte.

Behaviour:
- Reset: i_rstn low asynchronously forces o_dout = 8'h00; it is held while low.
- First valid data appears on the first rising edge after i_rstn deasserts.
- Read latency: exactly 1 cycle. On each rising edge o_dout <= ROM[i_addr sampled at that edge].
- No enable: the output updates every cycle. The same address held keeps o_dout stable.
- Contents (fixed, hex ASCII):
  - addr 0..25 = 'A'..'Z' (8'h41 + addr).
  - addr 26..29 = '0'..'3' (8'h30..8'h33).
  - addr 30 = 8'h0D (CR).
  - addr 31 = 8'h0A (LF).
- ROM_ADDR_WIDTH > 5: addresses 32..2**W-1 return 8'h00 (NUL, end-of-message marker).
- ROM_ADDR_WIDTH < 5: only entries 0..2**W-1 are reachable; contents are unchanged.
- Address wrap (31 -> 0) needs no special handling; each cycle is independent.
- Reset mid-stream: o_dout goes to 8'h00 immediately, not on a clock edge. After release, the normal 1-cycle latency resumes.
- X or Z on i_addr: o_dout goes to 8'h00, not X. This is sim-only behaviour via a default case branch.
- Implement the table as a case statement or constant array so it infers LUT/BRAM ROM. It needs no initialisation file.

Optional Feature:
- Macro CHAR_ROM_OUTREG_EN.
- Defined:
  - Adds a second output register stage, so read latency is 2 cycles.
  - Both stages reset to 8'h00 asynchronously on i_rstn low.
  - Intended for BRAM output-register timing closure.
- Undefined: single register, 1-cycle latency as above.
- The port list is identical in both builds.

Decomposition:
- Package char_rom_pkg holds:
  - localparam CHAR_ROM_DEPTH = 32.
  - ASCII constants ASCII_NUL, ASCII_CR, ASCII_LF, ASCII_A, ASCII_0.
  - Function char_rom_lookup(addr) that returns the table byte, shared with the UART sequencer and bench reference model.
- No sub-module: the block is a single always_ff around a combinational lookup.

Test Plan:
- Reset: hold i_rstn low with i_addr=5 for 10 cycles -> o_dout = 8'h00 throughout; first edge after release -> o_dout = 8'h46 ('F').
- Full sweep: i_addr = 0..31, one per cycle -> o_dout one cycle later is the sequence "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123" then 8'h0D, 8'h0A.
- Wrap: i_addr 30, 31, 0, 1 -> o_dout 8'h0D, 8'h0A, 8'h41, 8'h42, each one cycle after its address.
- Mid-stream reset: assert i_rstn low between edges while o_dout = 8'h4B -> o_dout = 8'h00 before the next edge; release with i_addr=2 -> 8'h43 on the next edge.
- ROM_ADDR_WIDTH=6: i_addr = 32 and i_addr = 63 -> 8'h00; i_addr = 25 -> 8'h5A.
- CHAR_ROM_OUTREG_EN defined: i_addr = 0 then 1 -> 8'h41 appears two edges after address 0 is applied, 8'h42 on the following edge.
